// File: rtl/bit_serializer.sv
// bit_serializer: one-word-buffered parallel-to-serial front end, idle-high line; BIT_SERIALIZER_LSB_FIRST_EN selects LSB-first order.
module bit_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;
  logic              state;
  logic              hold_valid;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_next;
  logic [CW-1:0]     cnt;
  logic              at_last;
  logic              load;
  logic              head;
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
  assign head    = sh[0];
  assign sh_next = {1'b1, sh[DATA_W-1:1]};
`else
  assign head    = sh[DATA_W-1];
  assign sh_next = {sh[DATA_W-2:0], 1'b1};
`endif
  assign at_last   = cnt == CW'(DATA_W - 1);
  // a held word moves into the shifter from idle or on the last bit, so words run back to back
  assign load      = hold_valid && (state == IDLE || at_last);
  assign in_ready  = !hold_valid && !rst;
  assign ser_valid = state == SHIFT;
  assign ser_out   = (state == SHIFT) ? head : 1'b1;
  assign ser_last  = state == SHIFT && at_last;
  assign busy      = state == SHIFT || hold_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      hold       <= '0;
      sh         <= '1;
      cnt        <= '0;
    end else begin
      if (in_valid && !hold_valid) begin
        hold       <= in_data;
        hold_valid <= 1'b1;
      end
      if (state == SHIFT) begin
        sh  <= sh_next;
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        sh         <= hold;
        hold_valid <= 1'b0;
        cnt        <= '0;
        state      <= SHIFT;
      end else if (state == SHIFT && at_last) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench; accepted words are expanded into timed expected bits and a monitor compares every cycle.
module tb_bit_serializer;
  localparam int W = 8;
  logic         clk = 0;
  logic         rst = 0;
  logic         in_valid = 0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, ser_out, ser_valid, ser_last, busy;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  typedef struct {logic b; logic l; int c;} exp_t;
  exp_t q[$];
  int   last_a = -100;
  int   last_s = -100;
  int   tail = -100;
  bit   mon_en = 0;

  bit_serializer #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, a, e);
    end
  endtask

  // word accepted at edge a starts after the later of edge a+1 and the end of the previous word
  function automatic void push_word(logic [W-1:0] d, int a);
    int s;
    exp_t e;
    s = (a + 1 > tail + 1) ? a + 1 : tail + 1;
    for (int i = 0; i < W; i++) begin
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      e.b = d[i];
`else
      e.b = d[W-1-i];
`endif
      e.l = (i == W - 1);
      e.c = s + i;
      q.push_back(e);
    end
    last_a = a;
    last_s = s;
    tail = s + W - 1;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        chk("rst_ser_out", ser_out, 1);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
      end else begin
        bit pend, act;
        pend = last_a <= cyc && cyc < last_s;
        act = q.size() > 0 && q[0].c == cyc;
        chk("in_ready", in_ready, !pend);
        chk("busy", busy, pend || act);
        if (act) begin
          chk("ser_valid", ser_valid, 1);
          chk("ser_out", ser_out, q[0].b);
          chk("ser_last", ser_last, q[0].l);
          void'(q.pop_front());
        end else begin
          chk("idle_valid", ser_valid, 0);
          chk("idle_out", ser_out, 1);
          chk("idle_last", ser_last, 0);
        end
      end
    end
  end

  task automatic drive(logic v, logic [W-1:0] d, output bit acc);
    @(negedge clk);
    in_valid = v;
    in_data = d;
    acc = v && in_ready && !rst;
    if (acc) push_word(d, cyc + 1);
  endtask

  task automatic send(logic [W-1:0] d);
    bit acc = 0;
    for (int i = 0; i < 40 && !acc; i++) drive(1'b1, d, acc);
    chk("accept", acc, 1);
  endtask

  task automatic idle(int n);
    bit acc;
    repeat (n) drive(1'b0, '0, acc);
  endtask

  initial begin
    #1 rst = 1;
    #2;
    chk("por_ser_out", ser_out, 1);
    chk("por_ser_valid", ser_valid, 0);
    chk("por_ser_last", ser_last, 0);
    chk("por_busy", busy, 0);
    chk("por_in_ready", in_ready, 0);
    mon_en = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    send(8'h0B);
    idle(12);
    send(8'hA5);
    send(8'h3C);
    idle(20);
    send(8'hC3);
    idle(W + 5);
    send(8'h96);
    idle(15);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    idle(30);
    send(8'hF0);
    send(8'h0F);
    idle(3);
    @(posedge clk);
    #2;
    q.delete();
    last_a = -100;
    last_s = -100;
    tail = -100;
    rst = 1;
    #1;
    chk("async_rst_out", ser_out, 1);
    chk("async_rst_valid", ser_valid, 0);
    chk("async_rst_ready", in_ready, 0);
    chk("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);
    idle(20);
    repeat (400) begin
      bit acc;
      drive($urandom_range(0, 3) != 0, W'($urandom), acc);
    end
    idle(3 * W);
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
